// File: rtl/axi_sram_pkg.sv
// Shared encodings, FSM state types and burst address arithmetic for the AXI4 SRAM responder.
package axi_sram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_t;

  // Address of the following 8-byte beat; the reserved burst type holds its address like FIXED.
  function automatic logic [63:0] axi_next_addr(input logic [63:0] addr,
                                                input logic [7:0]  len,
                                                input logic [1:0]  burst);
    logic [63:0] incr;
    logic [63:0] mask;
    incr = addr + 64'd8;
    mask = {53'd0, len, 3'b111};
    case (burst)
      BURST_INCR: axi_next_addr = incr;
      BURST_WRAP: begin
        if (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)
          axi_next_addr = (addr & ~mask) | (incr & mask);
        else
          axi_next_addr = incr;
      end
      default: axi_next_addr = addr;
    endcase
  endfunction

endpackage

// File: rtl/axi_sram_dpram.sv
// DEPTH x 64-bit simple dual-port RAM: one byte-enabled write port, one read port with registered output.
module axi_sram_dpram #(
  parameter int DEPTH = 4096,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [63:0]      wdata,
  input  logic [7:0]       wstrb,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [63:0]      rdata
);

  // NOTE: the array carries no reset so it maps onto RAM macros; contents survive a bus reset.
  logic [63:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    for (int b = 0; b < 8; b++) begin
      if (we && wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
    // NOTE: non-blocking updates make a same-cycle read of the word being written return its old value.
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 responder backing a DEPTH x 64-bit SRAM; independent write and read burst engines.
module axi_sram_slave
  import axi_sram_pkg::*;
#(
  parameter int                ID_W      = 1,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h1000_0000),
  parameter int                DEPTH     = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ID_W-1:0]   s_axi_awid,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [63:0]       s_axi_wdata,
  input  logic [7:0]        s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [ID_W-1:0]   s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [7:0]        s_axi_arlen,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [ID_W-1:0]   s_axi_rid,
  output logic [63:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);

  localparam int                IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH * 8);

  wr_state_t         w_state;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len;
  logic [7:0]        w_beat;
  logic [1:0]        w_burst;
  logic              w_err;

  rd_state_t         r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic [7:0]        r_beat;
  logic [1:0]        r_burst;
  logic              r_zero;

  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-1:0] r_off;
  logic              w_in_range;
  logic              r_in_range;
  logic              w_hs;
  logic              w_is_last;
  logic              w_beat_err;
  logic [63:0]       ram_q;

  // The window is checked on the full byte offset so addresses below the base wrap to huge offsets.
  assign w_off      = w_addr - BASE_ADDR;
  assign r_off      = r_addr - BASE_ADDR;
  assign w_in_range = (w_addr >= BASE_ADDR) && (w_off < SPAN);
  assign r_in_range = (r_addr >= BASE_ADDR) && (r_off < SPAN);
  assign w_hs       = s_axi_wvalid && s_axi_wready;
  assign w_is_last  = (w_beat == w_len);
  assign w_beat_err = !w_in_range || (s_axi_wlast != w_is_last);

  axi_sram_dpram #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
    .clock (clock),
    .we    (w_hs && w_in_range),
    .waddr (w_off[IDX_W+2:3]),
    .wdata (s_axi_wdata),
    .wstrb (s_axi_wstrb),
    .re    (r_state == R_FETCH),
    .raddr (r_off[IDX_W+2:3]),
    .rdata (ram_q)
  );

  // RAM output is held between fetches, so gating it keeps R payload stable and zero when idle.
  assign s_axi_rdata = (s_axi_rvalid && !r_zero) ? ram_q : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= RESP_OKAY;
      w_addr        <= '0;
      w_len         <= '0;
      w_beat        <= '0;
      w_burst       <= BURST_FIXED;
      w_err         <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (s_axi_awvalid) begin
          w_state       <= W_DATA;
          s_axi_awready <= 1'b0;
          s_axi_wready  <= 1'b1;
          s_axi_bid     <= s_axi_awid;
          w_addr        <= s_axi_awaddr;
          w_len         <= s_axi_awlen;
          w_burst       <= s_axi_awburst;
          w_beat        <= '0;
          w_err         <= (s_axi_awburst == BURST_RSVD);
        end
        W_DATA: if (w_hs) begin
          if (w_is_last) begin
            w_state      <= W_RESP;
            s_axi_wready <= 1'b0;
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
          end else begin
            w_beat <= w_beat + 8'd1;
            w_addr <= ADDR_W'(axi_next_addr(64'(w_addr), w_len, w_burst));
            w_err  <= w_err || w_beat_err;
          end
        end
        W_RESP: if (s_axi_bready) begin
          w_state       <= W_IDLE;
          s_axi_bvalid  <= 1'b0;
          s_axi_awready <= 1'b1;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rresp   <= RESP_OKAY;
      r_addr        <= '0;
      r_len         <= '0;
      r_beat        <= '0;
      r_burst       <= BURST_FIXED;
      r_zero        <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (s_axi_arvalid) begin
          r_state       <= R_FETCH;
          s_axi_arready <= 1'b0;
          s_axi_rid     <= s_axi_arid;
          r_addr        <= s_axi_araddr;
          r_len         <= s_axi_arlen;
          r_burst       <= s_axi_arburst;
          r_beat        <= '0;
        end
        R_FETCH: begin
          r_state      <= R_DATA;
          s_axi_rvalid <= 1'b1;
          s_axi_rlast  <= (r_beat == r_len);
          s_axi_rresp  <= (!r_in_range || r_burst == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
          r_zero       <= !r_in_range;
        end
        R_DATA: if (s_axi_rready) begin
          s_axi_rvalid <= 1'b0;
          s_axi_rlast  <= 1'b0;
          if (r_beat == r_len) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b1;
          end else begin
            r_state <= R_FETCH;
            r_beat  <= r_beat + 8'd1;
            r_addr  <= ADDR_W'(axi_next_addr(64'(r_addr), r_len, r_burst));
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: stimulus queues expected B/R responses, a monitor pops and compares.
module tb_axi_sram_slave;
  import axi_sram_pkg::*;

  localparam int          ID_W   = 2;
  localparam int          ADDR_W = 32;
  localparam int          DEPTH  = 256;
  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam int          BOUND  = 200;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [ID_W-1:0]   s_axi_awid;
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic [7:0]        s_axi_awlen;
  logic [1:0]        s_axi_awburst;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic [63:0]       s_axi_wdata;
  logic [7:0]        s_axi_wstrb;
  logic              s_axi_wlast;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  logic [ID_W-1:0]   s_axi_bid;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready;
  logic [ID_W-1:0]   s_axi_arid;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic [7:0]        s_axi_arlen;
  logic [1:0]        s_axi_arburst;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [ID_W-1:0]   s_axi_rid;
  logic [63:0]       s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rlast;
  logic              s_axi_rvalid;
  logic              s_axi_rready;

  always #5 clock = ~clock;

  axi_sram_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [63:0]     data;
    logic [1:0]      resp;
    logic            last;
  } r_exp_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_exp_t;

  r_exp_t      rq[$];
  b_exp_t      bq[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [63:0] wd [16];
  logic        r_hold = 1'b0;
  logic        b_hold = 1'b0;
  r_exp_t      r_prev;
  b_exp_t      b_prev;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: no matching handshake within bound", name);
  endtask

  // Monitor: payload stability while stalled, and scoreboard pops on every B/R handshake.
  always @(negedge clock) begin
    r_exp_t r_got;
    b_exp_t b_got;
    r_got = '{id: s_axi_rid, data: s_axi_rdata, resp: s_axi_rresp, last: s_axi_rlast};
    b_got = '{id: s_axi_bid, resp: s_axi_bresp};
    if (reset) begin
      r_hold = 1'b0;
      b_hold = 1'b0;
    end else begin
      if (r_hold) check("r_stall_hold", 128'({s_axi_rvalid, r_got}), 128'({1'b1, r_prev}));
      if (b_hold) check("b_stall_hold", 128'({s_axi_bvalid, b_got}), 128'({1'b1, b_prev}));
      if (s_axi_rvalid && s_axi_rready) begin
        if (rq.size() == 0) fail_now("r_unexpected");
        else check("r_beat", 128'(r_got), 128'(rq.pop_front()));
      end
      if (s_axi_bvalid && s_axi_bready) begin
        if (bq.size() == 0) fail_now("b_unexpected");
        else check("b_resp", 128'(b_got), 128'(bq.pop_front()));
      end
      r_hold = s_axi_rvalid && !s_axi_rready;
      r_prev = r_got;
      b_hold = s_axi_bvalid && !s_axi_bready;
      b_prev = b_got;
    end
  end

  function automatic logic ready_of(input int ch);
    case (ch)
      0:       ready_of = s_axi_awready;
      1:       ready_of = s_axi_wready;
      default: ready_of = s_axi_arready;
    endcase
  endfunction

  // Called at posedge+1 with valid asserted; returns at posedge+1 after the accepting edge.
  task automatic handshake(input int ch, input string name);
    logic ok;
    int   n = 0;
    do begin
      ok = ready_of(ch);
      @(posedge clock); #1;
      n++;
    end while (!ok && n < BOUND);
    if (!ok) fail_now(name);
  endtask

  task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [7:0] strb, input int last_at,
                          input logic [1:0] exp_resp);
    bq.push_back('{id: id, resp: exp_resp});
    s_axi_awid    = id;
    s_axi_awaddr  = addr;
    s_axi_awlen   = len;
    s_axi_awburst = burst;
    s_axi_awvalid = 1'b1;
    handshake(0, "aw_handshake");
    s_axi_awvalid = 1'b0;
    check("aw_to_wready", 128'(s_axi_wready), 128'(1'b1));
    for (int i = 0; i <= int'(len); i++) begin
      s_axi_wdata  = wd[i];
      s_axi_wstrb  = strb;
      s_axi_wlast  = (i == last_at);
      s_axi_wvalid = 1'b1;
      handshake(1, "w_handshake");
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    check("wlast_to_bvalid", 128'(s_axi_bvalid), 128'(1'b1));
  endtask

  task automatic push_r(input logic [ID_W-1:0] id, input logic [63:0] data, input logic [1:0] resp,
                        input logic last);
    rq.push_back('{id: id, data: data, resp: resp, last: last});
  endtask

  task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    s_axi_arid    = id;
    s_axi_araddr  = addr;
    s_axi_arlen   = len;
    s_axi_arburst = burst;
    s_axi_arvalid = 1'b1;
    handshake(2, "ar_handshake");
    s_axi_arvalid = 1'b0;
    check("ar_to_rvalid_c1", 128'(s_axi_rvalid), 128'(1'b0));
    @(posedge clock); #1;
    check("ar_to_rvalid_c2", 128'(s_axi_rvalid), 128'(1'b1));
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < BOUND) begin
      @(posedge clock); #1;
      n++;
    end
    if (rq.size() != 0 || bq.size() != 0) begin
      fail_now("drain_timeout");
      rq.delete();
      bq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awburst = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arburst = '0; s_axi_arvalid = 1'b0;
    s_axi_bready = 1'b1;
    s_axi_rready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset_ctrl", 128'({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid,
                               s_axi_rvalid, s_axi_rlast}), 128'(6'b110000));
    check("reset_payload", 128'({s_axi_bid, s_axi_rid, s_axi_rdata, s_axi_bresp, s_axi_rresp}), 128'(0));

    // INCR write of words 8..11, read back with a different ID
    wd[0] = 64'hA000_0000_0000_0008; wd[1] = 64'hA000_0000_0000_0009;
    wd[2] = 64'hA000_0000_0000_000A; wd[3] = 64'hA000_0000_0000_000B;
    do_write(2'd1, BASE + 32'h40, 8'd3, BURST_INCR, 8'hFF, 3, RESP_OKAY);
    drain();
    push_r(2'd2, 64'hA000_0000_0000_0008, RESP_OKAY, 1'b0);
    push_r(2'd2, 64'hA000_0000_0000_0009, RESP_OKAY, 1'b0);
    push_r(2'd2, 64'hA000_0000_0000_000A, RESP_OKAY, 1'b0);
    push_r(2'd2, 64'hA000_0000_0000_000B, RESP_OKAY, 1'b1);
    do_read(2'd2, BASE + 32'h40, 8'd3, BURST_INCR);
    drain();

    // Words 0..3, then a WRAP read starting at word 3 visits 3,0,1,2
    wd[0] = 64'hC000_0000_0000_0000; wd[1] = 64'hC000_0000_0000_0001;
    wd[2] = 64'hC000_0000_0000_0002; wd[3] = 64'hC000_0000_0000_0003;
    do_write(2'd0, BASE, 8'd3, BURST_INCR, 8'hFF, 3, RESP_OKAY);
    drain();
    push_r(2'd3, 64'hC000_0000_0000_0003, RESP_OKAY, 1'b0);
    push_r(2'd3, 64'hC000_0000_0000_0000, RESP_OKAY, 1'b0);
    push_r(2'd3, 64'hC000_0000_0000_0001, RESP_OKAY, 1'b0);
    push_r(2'd3, 64'hC000_0000_0000_0002, RESP_OKAY, 1'b1);
    do_read(2'd3, BASE + 32'h18, 8'd3, BURST_WRAP);
    drain();

    // FIXED burst of three beats to word 16: the last beat wins
    wd[0] = 64'hE000_0000_0000_0000; wd[1] = 64'hE000_0000_0000_0001; wd[2] = 64'hE000_0000_0000_0002;
    do_write(2'd1, BASE + 32'h80, 8'd2, BURST_FIXED, 8'hFF, 2, RESP_OKAY);
    drain();
    push_r(2'd1, 64'hE000_0000_0000_0002, RESP_OKAY, 1'b1);
    do_read(2'd1, BASE + 32'h80, 8'd0, BURST_INCR);
    drain();

    // Byte strobes: clear only the low four bytes of an all-ones word
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_write(2'd2, BASE + 32'hA0, 8'd0, BURST_INCR, 8'hFF, 0, RESP_OKAY);
    wd[0] = 64'h0;
    do_write(2'd2, BASE + 32'hA0, 8'd0, BURST_INCR, 8'h0F, 0, RESP_OKAY);
    drain();
    push_r(2'd0, 64'hFFFF_FFFF_0000_0000, RESP_OKAY, 1'b1);
    do_read(2'd0, BASE + 32'hA0, 8'd0, BURST_INCR);
    drain();

    // Burst running off the top of the window: second beat out of range
    wd[0] = 64'hF000_0000_0000_0000; wd[1] = 64'hF000_0000_0000_0001;
    do_write(2'd3, BASE + DEPTH * 8 - 8, 8'd1, BURST_INCR, 8'hFF, 1, RESP_SLVERR);
    drain();
    push_r(2'd1, 64'hF000_0000_0000_0000, RESP_OKAY, 1'b0);
    push_r(2'd1, 64'h0, RESP_SLVERR, 1'b1);
    do_read(2'd1, BASE + DEPTH * 8 - 8, 8'd1, BURST_INCR);
    drain();

    // Back-pressure on B and on R for ten cycles each
    s_axi_bready = 1'b0;
    wd[0] = 64'h5555_AAAA_5555_AAAA;
    do_write(2'd2, BASE + 32'hC0, 8'd0, BURST_INCR, 8'hFF, 0, RESP_OKAY);
    repeat (10) @(posedge clock);
    #1;
    s_axi_bready = 1'b1;
    drain();
    s_axi_rready = 1'b0;
    push_r(2'd3, 64'h5555_AAAA_5555_AAAA, RESP_OKAY, 1'b1);
    do_read(2'd3, BASE + 32'hC0, 8'd0, BURST_INCR);
    repeat (10) @(posedge clock);
    #1;
    s_axi_rready = 1'b1;
    drain();

    // Early wlast on beat 2 of 4, then the reserved burst encoding
    wd[0] = 64'h7; wd[1] = 64'h8; wd[2] = 64'h9; wd[3] = 64'hA;
    do_write(2'd3, BASE + 32'h100, 8'd3, BURST_INCR, 8'hFF, 1, RESP_SLVERR);
    drain();
    wd[0] = 64'h0;
    do_write(2'd0, BASE + 32'h120, 8'd0, BURST_RSVD, 8'hFF, 0, RESP_SLVERR);
    drain();

    // Reset pulse in the middle of a read burst
    push_r(2'd1, 64'hA000_0000_0000_0008, RESP_OKAY, 1'b0);
    push_r(2'd1, 64'hA000_0000_0000_0009, RESP_OKAY, 1'b0);
    push_r(2'd1, 64'hA000_0000_0000_000A, RESP_OKAY, 1'b0);
    push_r(2'd1, 64'hA000_0000_0000_000B, RESP_OKAY, 1'b1);
    do_read(2'd1, BASE + 32'h40, 8'd3, BURST_INCR);
    n = 0;
    while (rq.size() > 3 && n < BOUND) begin
      @(posedge clock); #1;
      n++;
    end
    if (rq.size() > 3) fail_now("mid_read_first_beat");
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    rq.delete();
    check("reset_mid_read", 128'({s_axi_rvalid, s_axi_arready, s_axi_wready, s_axi_bvalid}),
          128'(4'b0100));
    push_r(2'd2, 64'hA000_0000_0000_0008, RESP_OKAY, 1'b0);
    push_r(2'd2, 64'hA000_0000_0000_0009, RESP_OKAY, 1'b0);
    push_r(2'd2, 64'hA000_0000_0000_000A, RESP_OKAY, 1'b0);
    push_r(2'd2, 64'hA000_0000_0000_000B, RESP_OKAY, 1'b1);
    do_read(2'd2, BASE + 32'h40, 8'd3, BURST_INCR);
    drain();
    push_r(2'd0, 64'hC000_0000_0000_0000, RESP_OKAY, 1'b0);
    push_r(2'd0, 64'hC000_0000_0000_0001, RESP_OKAY, 1'b0);
    push_r(2'd0, 64'hC000_0000_0000_0002, RESP_OKAY, 1'b0);
    push_r(2'd0, 64'hC000_0000_0000_0003, RESP_OKAY, 1'b1);
    do_read(2'd0, BASE, 8'd3, BURST_INCR);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
